// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder slice (two half adders plus a carry OR)
// with a registered carry. Operands are consumed LSB first, one bit per clock.

module serial_adder_ctrl_ha (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               busy_d;
    logic               done_d;

    logic [WIDTH-1:0]   shift_a;
    logic [WIDTH-1:0]   shift_b;
    logic [WIDTH-1:0]   result;
    logic [WIDTH-1:0]   result_next;
    logic               carry;
    logic [CNT_W-1:0]   bit_cnt;

    logic               load;
    logic               step;
    logic               last_bit;

    logic               ha0_s;
    logic               ha0_c;
    logic               slice_sum;
    logic               ha1_c;
    logic               slice_cout;

    // Bit slice: (a0 ^ b0) ^ c, carry = a0&b0 | c&(a0^b0)
    serial_adder_ctrl_ha u_ha0 (
        .x (shift_a[0]),
        .y (shift_b[0]),
        .s (ha0_s),
        .c (ha0_c)
    );

    serial_adder_ctrl_ha u_ha1 (
        .x (ha0_s),
        .y (carry),
        .s (slice_sum),
        .c (ha1_c)
    );

    assign slice_cout  = ha0_c | ha1_c;
    assign result_next = {slice_sum, result[WIDTH-1:1]};

    // Start is only honoured outside ADD; reset dominates everything
    assign load     = (state != ADD) && start_in;
    assign step     = (state == ADD);
    assign last_bit = step && (bit_cnt == CNT_W'(WIDTH - 1));

    // State register with registered status outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= IDLE;
            busy_out <= 1'b0;
            done_out <= 1'b0;
        end else begin
            state    <= state_next;
            busy_out <= busy_d;
            done_out <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_in) state_next = ADD;
            ADD:     if (last_bit) state_next = DONE;
            DONE:    state_next = start_in ? ADD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the upcoming state so they line up with it
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_next)
            ADD:     busy_d = 1'b1;
            DONE:    done_d = 1'b1;
            default: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
        endcase
    end

    // Operand/result shifting and result publication
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            shift_a   <= '0;
            shift_b   <= '0;
            result    <= '0;
            carry     <= 1'b0;
            bit_cnt   <= '0;
            sum_out   <= '0;
            carry_out <= 1'b0;
        end else if (load) begin
            shift_a <= a_in;
            shift_b <= b_in;
            carry   <= 1'b0;
            bit_cnt <= '0;
        end else if (step) begin
            shift_a <= {1'b0, shift_a[WIDTH-1:1]};
            shift_b <= {1'b0, shift_b[WIDTH-1:1]};
            result  <= result_next;
            carry   <= slice_cout;
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (last_bit) begin
                sum_out   <= result_next;
                carry_out <= slice_cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: an 8-bit instance for latency/control
// scenarios and a 4-bit instance swept over every operand pair.

module tb_serial_adder_ctrl;
    logic       clk;
    logic       rst;
    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       carry8;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       carry4;

    int total;
    int bad;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk_in    (clk),
        .rst_in    (rst),
        .start_in  (start8),
        .a_in      (a8),
        .b_in      (b8),
        .busy_out  (busy8),
        .done_out  (done8),
        .sum_out   (sum8),
        .carry_out (carry8)
    );

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk_in    (clk),
        .rst_in    (rst),
        .start_in  (start4),
        .a_in      (a4),
        .b_in      (b4),
        .busy_out  (busy4),
        .done_out  (done4),
        .sum_out   (sum4),
        .carry_out (carry4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One 8-bit addition with cycle-exact status checks around it
    task automatic run_op8(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] exp_sum, input logic exp_c);
        a8 = a;
        b8 = b;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("op_busy", 32'(busy8), 32'd1);
            check("op_nodone", 32'(done8), 32'd0);
            tick();
        end
        check("op_done", 32'(done8), 32'd1);
        check("op_busy_low", 32'(busy8), 32'd0);
        check("op_sum", 32'(sum8), 32'(exp_sum));
        check("op_carry", 32'(carry8), 32'(exp_c));
        tick();
        check("op_done_1cyc", 32'(done8), 32'd0);
        check("op_sum_hold", 32'(sum8), 32'(exp_sum));
    endtask

    initial begin
        int n;
        logic [4:0] ref4;
        total = 0;
        bad = 0;
        rst = 1'b1;
        start8 = 1'b0;
        a8 = '0;
        b8 = '0;
        start4 = 1'b0;
        a4 = '0;
        b4 = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_sum", 32'(sum8), 32'd0);
        check("rst_carry", 32'(carry8), 32'd0);
        tick();

        run_op8(8'h3C, 8'h15, 8'h51, 1'b0);
        run_op8(8'hFF, 8'h01, 8'h00, 1'b1);
        run_op8(8'hFF, 8'hFF, 8'hFE, 1'b1);

        // Back-to-back: start held high through the DONE cycle
        a8 = 8'h01;
        b8 = 8'h02;
        start8 = 1'b1;
        tick();
        a8 = 8'h80;
        b8 = 8'h80;
        for (int i = 0; i < 8; i++) begin
            check("b2b_busy1", 32'(busy8), 32'd1);
            tick();
        end
        check("b2b_done1", 32'(done8), 32'd1);
        check("b2b_sum1", 32'(sum8), 32'h03);
        check("b2b_carry1", 32'(carry8), 32'd0);
        tick();
        for (int i = 0; i < 8; i++) begin
            check("b2b_busy2", 32'(busy8), 32'd1);
            check("b2b_nodone2", 32'(done8), 32'd0);
            check("b2b_hold", 32'(sum8), 32'h03);
            tick();
        end
        start8 = 1'b0;
        check("b2b_done2", 32'(done8), 32'd1);
        check("b2b_sum2", 32'(sum8), 32'h00);
        check("b2b_carry2", 32'(carry8), 32'd1);
        tick();
        check("b2b_idle", 32'(busy8), 32'd0);
        check("b2b_done_low", 32'(done8), 32'd0);

        // Start and operand changes during ADD must not disturb the in-flight add
        a8 = 8'h3C;
        b8 = 8'h15;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("ign_busy", 32'(busy8), 32'd1);
            if (i == 2) begin
                start8 = 1'b1;
                a8 = 8'hFF;
                b8 = 8'hFF;
            end else if (i == 3) begin
                start8 = 1'b0;
                a8 = 8'h12;
                b8 = 8'hAA;
            end
            tick();
        end
        check("ign_done", 32'(done8), 32'd1);
        check("ign_sum", 32'(sum8), 32'h51);
        check("ign_carry", 32'(carry8), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("ign_no_extra_done", 32'(done8), 32'd0);
        end

        // Reset in the 5th ADD cycle aborts the operation
        a8 = 8'hAA;
        b8 = 8'h55;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("abort_busy_pre", 32'(busy8), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_sum", 32'(sum8), 32'd0);
        check("abort_carry", 32'(carry8), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("abort_no_done", 32'(done8), 32'd0);
        end
        run_op8(8'hAA, 8'h55, 8'hFF, 1'b0);

        // Reset coincident with start: start dropped
        a8 = 8'h11;
        b8 = 8'h22;
        rst = 1'b1;
        start8 = 1'b1;
        tick();
        rst = 1'b0;
        start8 = 1'b0;
        check("rst_start_busy", 32'(busy8), 32'd0);
        tick();
        check("rst_start_busy2", 32'(busy8), 32'd0);

        // Exhaustive 4-bit sweep
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                a4 = 4'(a);
                b4 = 4'(b);
                ref4 = 5'(a + b);
                start4 = 1'b1;
                tick();
                start4 = 1'b0;
                n = 0;
                while (!done4 && n < 10) begin
                    tick();
                    n++;
                end
                check("w4_latency", 32'(n), 32'd4);
                check("w4_result", 32'({carry4, sum4}), 32'(ref4));
                tick();
                check("w4_done_1cyc", 32'(done4), 32'd0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
